// File: rtl/store_monitor_pkg.sv
// Shared state encoding and verdict codes for the store monitor.
package store_monitor_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TOUT
  } monState;

  localparam logic [1:0] VERD_NONE = 2'd0;
  localparam logic [1:0] VERD_PASS = 2'd1;
  localparam logic [1:0] VERD_FAIL = 2'd2;
  localparam logic [1:0] VERD_TOUT = 2'd3;

  function automatic logic [1:0] verdictOf(input monState s);
    case (s)
      S_PASS:  return VERD_PASS;
      S_FAIL:  return VERD_FAIL;
      S_TOUT:  return VERD_TOUT;
      default: return VERD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/store_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/store_monitor.sv
// Watches a store bus and latches a pass/fail/timeout verdict.
// Optional store counter output enabled by STORE_MONITOR_STATS_EN.
//
// state  | meaning
// S_IDLE | waiting for enable, stores ignored
// S_RUN  | monitoring stores, cycle counter running
// S_PASS | PASS_DATA seen at PASS_ADDR (sticky)
// S_FAIL | bad store captured in fail_addr/fail_data (sticky)
// S_TOUT | TIMEOUT RUN edges elapsed without a verdict (sticky)
module store_monitor
  import store_monitor_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int PASS_ADDR   = 100,
  parameter int PASS_DATA   = 25,
  parameter int IGNORE_ADDR = 96,
  parameter int TIMEOUT     = 1000,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
`ifdef STORE_MONITOR_STATS_EN
  ,
  output logic [CNT_W-1:0]  store_count
`endif
);

  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  monState state, nextState;
  logic [CNT_W-1:0] cycleCount;
  logic [1:0] verd;
  logic startRun;
  logic isRun;
  logic timeLimit;

  assign startRun  = (state == S_IDLE) && enable && !clear;
  assign isRun     = (state == S_RUN);
  assign timeLimit = (TIMEOUT != 0) && (cycleCount == CNT_W'(TO_LAST));

  sat_counter #(.WIDTH(CNT_W)) cycleCtr (
    .clk   (clk),
    .reset (reset),
    .clear (clear | startRun),
    .inc   (isRun),
    .count (cycleCount)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      S_IDLE: begin
        if (enable) nextState = S_RUN;
      end
      S_RUN: begin
        if (mem_write) begin
          if (data_addr == ADDR_W'(PASS_ADDR)) begin
            nextState = (write_data == DATA_W'(PASS_DATA)) ? S_PASS : S_FAIL;
          end else if (data_addr != ADDR_W'(IGNORE_ADDR)) begin
            nextState = S_FAIL;
          end
        end
        // a store verdict outranks the timeout on the same edge
        if ((nextState == S_RUN) && timeLimit) nextState = S_TOUT;
      end
      default: nextState = state;
    endcase
    if (clear) nextState = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fail_addr <= '0;
      fail_data <= '0;
    end else if (clear) begin
      fail_addr <= '0;
      fail_data <= '0;
    end else if (isRun && (nextState == S_FAIL)) begin
      fail_addr <= data_addr;
      fail_data <= write_data;
    end
  end

  assign verd    = verdictOf(state);
  assign done    = (verd != VERD_NONE);
  assign pass    = (verd == VERD_PASS);
  assign fail    = (verd == VERD_FAIL);
  assign timeout = (verd == VERD_TOUT);

`ifdef STORE_MONITOR_STATS_EN
  sat_counter #(.WIDTH(CNT_W)) storeCtr (
    .clk   (clk),
    .reset (reset),
    .clear (clear | startRun),
    .inc   (isRun && mem_write),
    .count (store_count)
  );
`endif

endmodule

// File: doc/store_monitor.md
STORE_MONITOR -- requirements
Module: store_monitor

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of the store data bus.
REQ-002 SHALL have parameter ADDR_W, default 32, width of the store address bus.
REQ-003 SHALL have parameter PASS_ADDR, default 100, the address whose store decides the verdict.
REQ-004 SHALL have parameter PASS_DATA, default 25, the value required at PASS_ADDR for a pass.
REQ-005 SHALL have parameter IGNORE_ADDR, default 96, a scratch address whose stores are tolerated.
REQ-006 SHALL have parameter TIMEOUT, default 1000, the RUN-cycle limit; 0 disables the timeout.
REQ-007 SHALL have parameter CNT_W, default 16, width of the cycle and store counters.
REQ-008 SHALL have port clk, input, 1 bit, the single clock, rising edge.
REQ-009 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-010 SHALL have port enable, input, 1 bit, start monitoring.
REQ-011 SHALL have port clear, input, 1 bit, synchronous return to IDLE.
REQ-012 SHALL have port mem_write, input, 1 bit, store strobe.
REQ-013 SHALL have port data_addr, input, ADDR_W bits, store address.
REQ-014 SHALL have port write_data, input, DATA_W bits, store data.
REQ-015 SHALL have port done, output, 1 bit, high in any terminal state.
REQ-016 SHALL have ports pass, fail and timeout, outputs, 1 bit each, one-hot verdict.
REQ-017 SHALL have ports fail_addr (ADDR_W) and fail_data (DATA_W), outputs, capturing the offending store.

Function
REQ-018 SHALL implement the states IDLE, RUN, PASS, FAIL and TOUT.
REQ-019 SHALL move IDLE->RUN at the first rising edge with enable=1; in IDLE, mem_write SHALL be ignored.
REQ-020 SHALL, in RUN at a rising edge with mem_write=1 and data_addr==PASS_ADDR and write_data==PASS_DATA, go to PASS.
REQ-021 SHALL, in RUN at a rising edge with mem_write=1 and data_addr==PASS_ADDR but write_data!=PASS_DATA, go to FAIL.
REQ-022 SHALL, in RUN at a rising edge with mem_write=1 and data_addr not equal to PASS_ADDR or IGNORE_ADDR, go to FAIL.
REQ-023 SHALL keep RUN on a store to IGNORE_ADDR.
REQ-024 SHALL, on entry to FAIL, capture data_addr and write_data into fail_addr and fail_data at the same edge.
REQ-025 SHALL clear the cycle counter on IDLE->RUN and increment it on every RUN edge, saturating at its maximum.
REQ-026 SHALL go to TOUT when TIMEOUT!=0 and the counter reaches TIMEOUT-1 without a verdict, so that TOUT is entered exactly TIMEOUT edges after entering RUN.
REQ-027 SHALL give a store verdict priority over timeout when both occur on the same edge.
REQ-028 SHALL, when clear=1 at an edge, return to IDLE from any state, zero the counters and capture registers, and take priority over every transition including a verdict.
REQ-029 SHALL make PASS, FAIL and TOUT sticky until clear or reset, ignoring enable and mem_write.
REQ-030 SHALL drive all outputs from registers, so the verdict is visible immediately after the deciding edge with 1-edge latency and no combinational path from inputs.
REQ-031 SHALL leave enable deasserting in RUN without effect; monitoring continues.

Reset
REQ-032 SHALL, while reset=1, asynchronously force state to IDLE and done, pass, fail, timeout, fail_addr, fail_data and the counters to 0.
REQ-033 SHALL, when reset is asserted mid-RUN, discard any pending verdict; after release the block SHALL require enable again.

Configuration
REQ-034 SHALL, with STORE_MONITOR_STATS_EN defined, provide output store_count (CNT_W bits), counting accepted RUN stores (including IGNORE_ADDR stores and the deciding store), saturating, frozen in terminal states and zeroed by clear and reset.
REQ-035 SHALL, without STORE_MONITOR_STATS_EN, have no store_count port and no associated logic, with all other behaviour identical.

Structure
REQ-036 SHALL place the state encoding typedef (IDLE, RUN, PASS, FAIL, TOUT) and verdict code constants in shared package store_monitor_pkg.
REQ-037 SHALL instantiate one sub-module, sat_counter (parametrised width, clear, increment, saturate), for the cycle counter and store_count.

Verification
REQ-038 SHALL pass this scenario: enable, then three stores to 96, then a store 25 at 100 -> pass=1 and done=1 one edge after the deciding store; fail=0.
REQ-039 SHALL pass this scenario: enable, then a store 7 at 100 -> fail=1, fail_addr=100, fail_data=7.
REQ-040 SHALL pass this scenario: enable, then a store 25 at 104 -> fail=1, fail_addr=104.
REQ-041 SHALL pass this scenario: TIMEOUT=8, enable, no stores -> timeout=1 exactly 8 edges after entering RUN; with a 25@100 store on edge 8 -> pass=1 and timeout=0.
REQ-042 SHALL pass this scenario: in PASS, a store 7 at 100 -> pass stays 1; then clear -> IDLE with all outputs 0; then clear with a simultaneous 25@100 store -> IDLE.
REQ-043 SHALL pass this scenario: reset pulse mid-RUN after two 96 stores -> outputs 0 immediately; with STORE_MONITOR_STATS_EN defined, store_count=0.
